// File: rtl/idma_wr_arb.sv
// idma_wr_arb: round-robin arbiter sharing one iDMA write channel between
// NUM_REQ requesters. A descriptor is granted combinationally in IDLE, then
// the data port is locked to the winner until its word count has drained.
module idma_wr_arb #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int AXI_ADDR_WID = 32,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = 32
) (
    input  logic                              cclk,
    input  logic                              rst_n,
    input  logic                              arb_init,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WID-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]             req_num,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_data_valid,
    input  logic [NUM_REQ*AXI_DATA_WID-1:0]   req_data,
    input  logic [NUM_REQ*AXI_STRBW-1:0]      req_strb,
    output logic [NUM_REQ-1:0]                req_data_ready,
    output logic                              wr_req,
    output logic [AXI_ADDR_WID-1:0]           wr_addr,
    output logic [31:0]                       wr_num,
    input  logic                              wr_addr_ready,
    output logic                              wr_data_valid,
    output logic [AXI_DATA_WID-1:0]           wr_data,
    output logic [AXI_STRBW-1:0]              wr_strb,
    input  logic                              wr_data_ready,
    output logic [ID_W-1:0]                   grant_id,
    output logic                              arb_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;

    // Per-requester views of the flattened buses
    logic [AXI_ADDR_WID-1:0] addr_arr [NUM_REQ];
    logic [31:0]             num_arr  [NUM_REQ];
    logic [AXI_DATA_WID-1:0] data_arr [NUM_REQ];
    logic [AXI_STRBW-1:0]    strb_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*AXI_ADDR_WID +: AXI_ADDR_WID];
        assign num_arr[gi]  = req_num[gi*32 +: 32];
        assign data_arr[gi] = req_data[gi*AXI_DATA_WID +: AXI_DATA_WID];
        assign strb_arr[gi] = req_strb[gi*AXI_STRBW +: AXI_STRBW];
    end

    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    int              search_sum;
    logic            arb_ok;
    logic            data_phase;
    logic            hs;

    // Round-robin search: first valid requester at or above ptr, wrapping
    always_comb begin
        found      = 1'b0;
        win        = '0;
        cand       = '0;
        search_sum = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_sum = int'(ptr_q) + k;
            if (search_sum >= NUM_REQ) begin
                search_sum = search_sum - NUM_REQ;
            end
            cand = ID_W'(search_sum);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // The channel pushes unconditionally, so a grant also needs address room
    assign arb_ok     = (state_q == ST_IDLE) && found && wr_addr_ready && !arb_init;
    assign data_phase = (state_q == ST_DATA) && !arb_init;
    assign hs         = wr_data_valid && wr_data_ready;

    // Descriptor and data muxes; idle outputs are held at zero
    always_comb begin
        wr_req         = arb_ok;
        req_ready      = '0;
        wr_addr        = '0;
        wr_num         = '0;
        wr_data_valid  = 1'b0;
        wr_data        = '0;
        wr_strb        = '0;
        req_data_ready = '0;
        if (arb_ok) begin
            req_ready[win] = 1'b1;
            wr_addr        = addr_arr[win];
            wr_num         = num_arr[win];
        end
        if (data_phase) begin
            wr_data_valid              = req_data_valid[grant_id_q];
            wr_data                    = data_arr[grant_id_q];
            wr_strb                    = strb_arr[grant_id_q];
            req_data_ready[grant_id_q] = wr_data_ready;
        end
    end

    // Next-state: grant bookkeeping in IDLE, beat countdown in DATA
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        if (arb_init) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            ptr_d      = '0;
            grant_id_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_ok) begin
                        grant_id_d = win;
                        ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
                        // Zero-length descriptors complete without a data phase
                        if (num_arr[win] != 32'd0) begin
                            cnt_d   = num_arr[win];
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        cnt_d = cnt_q - 32'd1;
                        if (cnt_q == 32'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign grant_id = grant_id_q;
    assign arb_busy = (state_q == ST_DATA);

endmodule

// File: tb/tb_idma_wr_arb.sv
// tb_idma_wr_arb: directed per-cycle vectors for idma_wr_arb plus hand-written
// reset sequences. Inputs change 1 ns after the rising edge, outputs are
// compared on the falling edge.
module tb_idma_wr_arb;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int SW = 32;

    logic              cclk = 1'b0;
    logic              rst_n;
    logic              arb_init;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*32-1:0]  req_num;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_data_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SW-1:0]  req_strb;
    logic [NR-1:0]     req_data_ready;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_num;
    logic              wr_addr_ready;
    logic              wr_data_valid;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_strb;
    logic              wr_data_ready;
    logic [IW-1:0]     grant_id;
    logic              arb_busy;

    idma_wr_arb #(
        .NUM_REQ(NR), .ID_W(IW), .AXI_ADDR_WID(AW), .AXI_DATA_WID(DW), .AXI_STRBW(SW)
    ) dut (
        .cclk(cclk), .rst_n(rst_n), .arb_init(arb_init),
        .req_valid(req_valid), .req_addr(req_addr), .req_num(req_num),
        .req_ready(req_ready), .req_data_valid(req_data_valid),
        .req_data(req_data), .req_strb(req_strb), .req_data_ready(req_data_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_num(wr_num),
        .wr_addr_ready(wr_addr_ready), .wr_data_valid(wr_data_valid),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_ready(wr_data_ready),
        .grant_id(grant_id), .arb_busy(arb_busy)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        logic          init;
        logic [3:0]    rv;
        logic [31:0]   num;
        logic          ardy;
        logic [3:0]    dv;
        logic          drdy;
        logic          e_wreq;
        logic [3:0]    e_rr;
        logic          e_wdv;
        logic [3:0]    e_rdr;
        logic [1:0]    e_gid;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_seen = 0;
    int   hs_exp = 0;

    function automatic logic [DW-1:0] pat_data(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [SW-1:0] pat_strb(input int i);
        return 32'h0F0F_0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic init, input logic [3:0] rv, input logic [31:0] num,
                       input logic ardy, input logic [3:0] dv, input logic drdy,
                       input logic e_wreq, input logic [3:0] e_rr, input logic e_wdv,
                       input logic [3:0] e_rdr, input logic [1:0] e_gid, input logic e_busy);
        vec_t v;
        v.init = init; v.rv = rv; v.num = num; v.ardy = ardy; v.dv = dv; v.drdy = drdy;
        v.e_wreq = e_wreq; v.e_rr = e_rr; v.e_wdv = e_wdv; v.e_rdr = e_rdr;
        v.e_gid = e_gid; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic set_num(input logic [31:0] num);
        for (int i = 0; i < NR; i++) req_num[i*32 +: 32] = num;
    endtask

    function automatic int onehot_idx(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    initial begin
        int w;
        // ---- Fixed per-requester payloads ----
        rst_n = 1'b0; arb_init = 1'b0; req_valid = '0; req_data_valid = '0;
        wr_addr_ready = 1'b0; wr_data_ready = 1'b0; req_num = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = 32'h1000 * 32'(i + 1);
            req_data[i*DW +: DW] = pat_data(i);
            req_strb[i*SW +: SW] = pat_strb(i);
        end

        // ---- Vector table ----
        // Req0 alone, 3 words
        add(0, 4'b0001, 3, 1, 4'b0001, 1,  1, 4'b0001, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 3, 1, 4'b0001, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(0, 4'b0000, 3, 1, 4'b0001, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(0, 4'b0000, 3, 1, 4'b0001, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(0, 4'b0000, 3, 1, 4'b0000, 1,  0, 4'b0000, 0, 4'b0000, 0, 0);
        // Abort clears ptr while everyone requests; then 1-word round robin
        add(1, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  1, 4'b0001, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  1, 4'b0010, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  1, 4'b0100, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0100, 2, 1);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  1, 4'b1000, 0, 4'b0000, 2, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b1000, 3, 1);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  1, 4'b0001, 0, 4'b0000, 3, 0);
        add(0, 4'b1111, 1, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        // Address FIFO full for 5 cycles with req2 pending, then zero-length grants
        add(1, 4'b0000, 0, 0, 4'b0000, 0,  0, 4'b0000, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0100, 0, 0, 4'b0000, 0,  0, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0100, 0, 1, 4'b0000, 0,  1, 4'b0100, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 0,  1, 4'b1000, 0, 4'b0000, 2, 0);
        add(0, 4'b1111, 0, 1, 4'b0000, 0,  1, 4'b0001, 0, 4'b0000, 3, 0);
        add(0, 4'b0101, 0, 1, 4'b0000, 0,  1, 4'b0100, 0, 4'b0000, 0, 0);
        // Req1, 4 words, with channel stalls and source gaps; others keep requesting
        add(0, 4'b0010, 4, 1, 4'b0000, 0,  1, 4'b0010, 0, 4'b0000, 2, 0);
        add(0, 4'b1111, 4, 1, 4'b1111, 0,  0, 4'b0000, 1, 4'b0000, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b1101, 1,  0, 4'b0000, 0, 4'b0010, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b0010, 0,  0, 4'b0000, 1, 4'b0000, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b0010, 1,  0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b0000, 0,  0, 4'b0000, 0, 4'b0000, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b0010, 1,  0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 4, 1, 4'b1111, 1,  0, 4'b0000, 1, 4'b0010, 1, 1);
        add(0, 4'b0000, 4, 1, 4'b0000, 1,  0, 4'b0000, 0, 4'b0000, 1, 0);
        // Req0, 8 words, aborted after 2 beats; next grant lowest valid index
        add(0, 4'b0001, 8, 1, 4'b0000, 0,  1, 4'b0001, 0, 4'b0000, 1, 0);
        add(0, 4'b0000, 8, 1, 4'b0001, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(0, 4'b0000, 8, 1, 4'b0001, 1,  0, 4'b0000, 1, 4'b0001, 0, 1);
        add(1, 4'b0000, 8, 1, 4'b0001, 1,  0, 4'b0000, 0, 4'b0000, 0, 1);
        add(0, 4'b1010, 0, 1, 4'b0000, 0,  1, 4'b0010, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0,  0, 4'b0000, 0, 4'b0000, 1, 0);

        // ---- Reset state ----
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        chk("rst.wr_req", 64'(wr_req), 0);
        chk("rst.req_ready", 64'(req_ready), 0);
        chk("rst.req_data_ready", 64'(req_data_ready), 0);
        chk("rst.wr_data_valid", 64'(wr_data_valid), 0);
        chk("rst.wr_addr", 64'(wr_addr), 0);
        chk("rst.wr_num", 64'(wr_num), 0);
        chk("rst.grant_id", 64'(grant_id), 0);
        chk("rst.arb_busy", 64'(arb_busy), 0);
        rst_n = 1'b1;
        @(negedge cclk);
        chk("post_rst.arb_busy", 64'(arb_busy), 0);
        chk("post_rst.grant_id", 64'(grant_id), 0);

        // ---- Table-driven cycles ----
        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            @(posedge cclk);
            #1;
            arb_init = v.init; req_valid = v.rv; set_num(v.num);
            wr_addr_ready = v.ardy; req_data_valid = v.dv; wr_data_ready = v.drdy;
            @(negedge cclk);
            $display("vec %0d: init=%0b rv=%b ardy=%0b dv=%b drdy=%0b -> wr_req=%0b rr=%b wdv=%0b rdr=%b gid=%0d busy=%0b",
                     n, v.init, v.rv, v.ardy, v.dv, v.drdy, wr_req, req_ready, wr_data_valid,
                     req_data_ready, grant_id, arb_busy);
            chk($sformatf("v%0d.wr_req", n), 64'(wr_req), 64'(v.e_wreq));
            chk($sformatf("v%0d.req_ready", n), 64'(req_ready), 64'(v.e_rr));
            chk($sformatf("v%0d.wr_data_valid", n), 64'(wr_data_valid), 64'(v.e_wdv));
            chk($sformatf("v%0d.req_data_ready", n), 64'(req_data_ready), 64'(v.e_rdr));
            chk($sformatf("v%0d.grant_id", n), 64'(grant_id), 64'(v.e_gid));
            chk($sformatf("v%0d.arb_busy", n), 64'(arb_busy), 64'(v.e_busy));
            if (v.e_wreq) begin
                w = onehot_idx(v.e_rr);
                chk($sformatf("v%0d.wr_addr", n), 64'(wr_addr), 64'(32'h1000 * 32'(w + 1)));
                chk($sformatf("v%0d.wr_num", n), 64'(wr_num), 64'(v.num));
            end else begin
                chk($sformatf("v%0d.wr_addr_idle", n), 64'(wr_addr), 0);
            end
            if (v.e_wdv) begin
                chk_wide($sformatf("v%0d.wr_data", n), wr_data, pat_data(int'(v.e_gid)));
                chk($sformatf("v%0d.wr_strb", n), 64'(wr_strb), 64'(pat_strb(int'(v.e_gid))));
            end
            if (wr_data_valid && wr_data_ready) hs_seen++;
            if (v.e_wdv && v.drdy) hs_exp++;
        end
        chk("handshake_total", 64'(hs_seen), 64'(hs_exp));

        // ---- Asynchronous reset in the middle of a data phase ----
        // ptr is 2 here, so req2 wins and grant_id becomes 2.
        @(posedge cclk);
        #1;
        arb_init = 1'b0; req_valid = 4'b0100; set_num(5); wr_addr_ready = 1'b1;
        req_data_valid = '0; wr_data_ready = 1'b0;
        @(negedge cclk);
        chk("async.wr_req", 64'(wr_req), 1);
        chk("async.req_ready", 64'(req_ready), 64'(4'b0100));
        @(posedge cclk);
        #1;
        req_valid = '0; req_data_valid = 4'b0100; wr_data_ready = 1'b1;
        #1;
        chk("async.busy_before", 64'(arb_busy), 1);
        chk("async.gid_before", 64'(grant_id), 2);
        $display("async: busy=%0b gid=%0d before reset", arb_busy, grant_id);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async.busy_after", 64'(arb_busy), 0);
        chk("async.gid_after", 64'(grant_id), 0);
        chk("async.wr_data_valid", 64'(wr_data_valid), 0);
        chk("async.req_data_ready", 64'(req_data_ready), 0);
        $display("async: busy=%0b gid=%0d after reset", arb_busy, grant_id);
        req_data_valid = '0;
        @(posedge cclk);
        #1;
        rst_n = 1'b1;
        @(negedge cclk);
        chk("async.idle_after", 64'(arb_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
